// File: rtl/call_scheduler.sv
// SCAN floor-call scheduler with door timing, SOS latching and an optional
// overweight interlock (define CALL_SCHEDULER_WEIGHT_INTERLOCK_EN to enable).
module call_scheduler #(
  parameter int unsigned DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       st_button,
  input  logic       nd_button,
  input  logic       rd_button,
  input  logic       sos_button,
  input  logic       weight_sensor,
  input  logic [1:0] current_floor,
  output logic       move_req,
  output logic       dir_up,
  output logic [1:0] target_floor,
  output logic       door_open,
  output logic [2:0] call_leds,
  output logic       sos_led,
  output logic       emergency_led,
  output logic       weight_led
);
  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN, EMERGENCY} state_e;

  localparam logic [3:0] DOOR_LAST = 4'(DOOR_CYCLES - 1);

  state_e     state_q;
  logic [2:0] btn_s_q, btn_p_q, pending_q;
  logic       sos_s_q, sos_p_q;
  logic [1:0] floor_q, target_q;
  logic [3:0] door_cnt_q;
  logic       dir_q, move_q, door_q, alarm_q, wled_q;

  logic [2:0] press, floor_oh, above_m, below_m, ahead_up, ahead_dn, served_d;
  logic [1:0] near_up, near_dn;
  logic       sos_edge, illegal, here_press, here_pend;
  logic       call_above, call_below, go_up, door_hold;

  // Floor decode; an illegal sampled floor matches nothing.
  always_comb begin
    floor_oh = 3'b000;
    above_m  = 3'b000;
    below_m  = 3'b000;
    case (floor_q)
      2'd0: begin floor_oh = 3'b001; above_m = 3'b110; end
      2'd1: begin floor_oh = 3'b010; above_m = 3'b100; below_m = 3'b001; end
      2'd2: begin floor_oh = 3'b100; below_m = 3'b011; end
      default: ;
    endcase
  end

  assign press      = btn_s_q & ~btn_p_q;
  assign sos_edge   = sos_s_q & ~sos_p_q;
  assign illegal    = (current_floor == 2'b11);
  assign here_press = |(press & floor_oh);
  assign here_pend  = |(pending_q & floor_oh);
  assign ahead_up   = pending_q & above_m;
  assign ahead_dn   = pending_q & below_m;
  assign call_above = |ahead_up;
  assign call_below = |ahead_dn;
  assign near_up    = ahead_up[1] ? 2'd1 : 2'd2;
  assign near_dn    = ahead_dn[1] ? 2'd1 : 2'd0;
  assign go_up      = call_above & (dir_q | ~call_below);
  // A stop serves the current floor, including a press arriving that cycle.
  assign served_d   = (pending_q | press) & ~floor_oh;

`ifdef CALL_SCHEDULER_WEIGHT_INTERLOCK_EN
  assign door_hold = weight_sensor;
`else
  logic unused_weight;
  assign unused_weight = weight_sensor;
  assign door_hold     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      btn_s_q    <= '0;
      btn_p_q    <= '0;
      sos_s_q    <= 1'b0;
      sos_p_q    <= 1'b0;
      floor_q    <= '0;
      pending_q  <= '0;
      target_q   <= '0;
      door_cnt_q <= '0;
      dir_q      <= 1'b1;
      move_q     <= 1'b0;
      door_q     <= 1'b0;
      alarm_q    <= 1'b0;
      wled_q     <= 1'b0;
    end else begin
      btn_s_q <= {rd_button, nd_button, st_button};
      btn_p_q <= btn_s_q;
      sos_s_q <= sos_button;
      sos_p_q <= sos_s_q;
      floor_q <= current_floor;
      wled_q  <= door_hold;
      if (state_q == EMERGENCY) begin
        if (sos_edge && !illegal) begin
          state_q <= IDLE;
          alarm_q <= 1'b0;
        end
      end else if (sos_edge || illegal) begin
        state_q <= EMERGENCY;
        move_q  <= 1'b0;
        door_q  <= 1'b0;
        alarm_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (here_press || here_pend) begin
              state_q    <= DOOR_OPEN;
              pending_q  <= served_d;
              door_q     <= 1'b1;
              door_cnt_q <= '0;
            end else begin
              pending_q <= pending_q | press;
              if (|pending_q) begin
                state_q  <= MOVING;
                move_q   <= 1'b1;
                dir_q    <= go_up;
                target_q <= go_up ? near_up : near_dn;
              end
            end
          end
          MOVING: begin
            if (here_pend) begin
              state_q    <= DOOR_OPEN;
              pending_q  <= served_d;
              move_q     <= 1'b0;
              door_q     <= 1'b1;
              door_cnt_q <= '0;
            end else begin
              pending_q <= pending_q | press;
              if (dir_q && call_above)       target_q <= near_up;
              else if (!dir_q && call_below) target_q <= near_dn;
            end
          end
          DOOR_OPEN: begin
            pending_q <= served_d;
            if (here_press) begin
              door_cnt_q <= '0;
            end else if (!door_hold) begin
              if (door_cnt_q == DOOR_LAST) begin
                state_q <= IDLE;
                door_q  <= 1'b0;
              end else begin
                door_cnt_q <= door_cnt_q + 4'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign move_req      = move_q;
  assign dir_up        = dir_q;
  assign target_floor  = target_q;
  assign door_open     = door_q;
  assign call_leds     = pending_q;
  assign sos_led       = alarm_q;
  assign emergency_led = alarm_q;
  assign weight_led    = wled_q;
endmodule

// File: tb/tb_call_scheduler.sv
// Directed scenarios plus a randomized run against a floor-level behavioural model.
module tb_call_scheduler;
  localparam int DC = 3;
`ifdef CALL_SCHEDULER_WEIGHT_INTERLOCK_EN
  localparam bit WEIGHT_EN = 1'b1;
`else
  localparam bit WEIGHT_EN = 1'b0;
`endif

  logic       clk, reset, st_button, nd_button, rd_button, sos_button, weight_sensor;
  logic [1:0] current_floor, target_floor;
  logic       move_req, dir_up, door_open, sos_led, emergency_led, weight_led;
  logic [2:0] call_leds;
  int checks = 0;
  int errors = 0;

  call_scheduler #(.DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .st_button(st_button), .nd_button(nd_button),
    .rd_button(rd_button), .sos_button(sos_button), .weight_sensor(weight_sensor),
    .current_floor(current_floor), .move_req(move_req), .dir_up(dir_up),
    .target_floor(target_floor), .door_open(door_open), .call_leds(call_leds),
    .sos_led(sos_led), .emergency_led(emergency_led), .weight_led(weight_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: modes 0 idle, 1 moving, 2 door, 3 emergency.
  int       m_mode, m_cnt, m_fl;
  bit [2:0] m_pend, m_bs, m_bp;
  bit       m_ss, m_sp, m_dir, m_move, m_door, m_alarm, m_wled;
  bit [1:0] m_target;

  function automatic int nearest(input bit [2:0] pend, input int fl, input bit up);
    if (fl > 2) return -1;
    if (up) begin
      for (int f = fl + 1; f <= 2; f++) if (pend[f]) return f;
    end else begin
      for (int f = fl - 1; f >= 0; f--) if (pend[f]) return f;
    end
    return -1;
  endfunction

  task automatic serve(input int fl, input bit [2:0] press);
    m_pend = m_pend | press;
    m_pend[fl] = 1'b0;
    m_mode = 2; m_door = 1; m_move = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit [2:0] press;
    bit sos_e, ill, here_p, here_c;
    int fl, up_f, dn_f, t;
    if (reset) begin
      m_mode = 0; m_pend = 0; m_dir = 1; m_target = 0; m_move = 0; m_door = 0;
      m_alarm = 0; m_wled = 0; m_bs = 0; m_bp = 0; m_ss = 0; m_sp = 0; m_fl = 0; m_cnt = 0;
      return;
    end
    press = m_bs & ~m_bp;
    sos_e = m_ss & ~m_sp;
    fl    = m_fl;
    ill   = (current_floor == 2'b11);
    m_bp = m_bs; m_bs = {rd_button, nd_button, st_button};
    m_sp = m_ss; m_ss = sos_button; m_fl = int'(current_floor);
    m_wled = WEIGHT_EN & weight_sensor;
    here_p = (fl < 3) && press[fl];
    here_c = (fl < 3) && m_pend[fl];
    if (m_mode == 3) begin
      if (sos_e && !ill) begin m_mode = 0; m_alarm = 0; end
      return;
    end
    if (sos_e || ill) begin
      m_mode = 3; m_move = 0; m_door = 0; m_alarm = 1;
      return;
    end
    case (m_mode)
      0: if (here_p || here_c) serve(fl, press);
         else begin
           if (m_pend != 0) begin
             up_f = nearest(m_pend, fl, 1'b1);
             dn_f = nearest(m_pend, fl, 1'b0);
             if (up_f >= 0 && (m_dir || dn_f < 0)) begin m_dir = 1; m_target = 2'(up_f); end
             else begin m_dir = 0; m_target = 2'(dn_f); end
             m_move = 1; m_mode = 1;
           end
           m_pend = m_pend | press;
         end
      1: if (here_c) serve(fl, press);
         else begin
           t = nearest(m_pend, fl, m_dir);
           if (t >= 0) m_target = 2'(t);
           m_pend = m_pend | press;
         end
      default: begin
        m_pend = m_pend | press;
        m_pend[fl] = 1'b0;
        if (here_p) m_cnt = 0;
        else if (!m_wled) begin
          if (m_cnt == DC - 1) begin m_mode = 0; m_door = 0; end
          else m_cnt++;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit [1:0] f);
    reset = 1; {rd_button, nd_button, st_button} = 3'b000; sos_button = 0;
    weight_sensor = 0; current_floor = f;
    tick(); tick();
    reset = 0;
  endtask

  task automatic pulse(input bit [2:0] b);
    {rd_button, nd_button, st_button} = b;
    tick();
    {rd_button, nd_button, st_button} = 3'b000;
  endtask

  task automatic sos_pulse();
    sos_button = 1; tick();
    sos_button = 0; tick();
  endtask

  task automatic test_reset();
    reset = 1; {rd_button, nd_button, st_button} = 3'b111; sos_button = 0;
    weight_sensor = 1; current_floor = 2'd1;
    tick(); tick();
    checks++;
    if ({move_req, dir_up, target_floor, door_open, call_leds, sos_led, emergency_led, weight_led} !== 11'b01000000000) begin
      errors++; $display("FAIL reset_values got %b want 01000000000",
        {move_req, dir_up, target_floor, door_open, call_leds, sos_led, emergency_led, weight_led});
    end
    reset = 0; {rd_button, nd_button, st_button} = 3'b000; weight_sensor = 0;
  endtask

  task automatic test_single_call();
    int n;
    do_reset(2'd0);
    pulse(3'b100);
    tick();
    checks++; if (call_leds !== 3'b100 || move_req !== 1'b0) begin errors++;
      $display("FAIL single_visible got leds=%b move=%b want leds=100 move=0", call_leds, move_req); end
    tick();
    checks++; if ({move_req, dir_up, target_floor} !== 4'b1110) begin errors++;
      $display("FAIL single_motion got %b want 1110", {move_req, dir_up, target_floor}); end
    current_floor = 2'd1; tick();
    current_floor = 2'd2; tick();
    checks++; if (move_req !== 1'b1 || door_open !== 1'b0) begin errors++;
      $display("FAIL single_prestop got move=%b door=%b want 1 0", move_req, door_open); end
    tick();
    checks++; if ({move_req, door_open, call_leds} !== 5'b01000) begin errors++;
      $display("FAIL single_stop got %b want 01000", {move_req, door_open, call_leds}); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!door_open) break;
      n++; tick();
    end
    checks++; if (n !== DC) begin errors++;
      $display("FAIL single_door_len got %0d want %0d", n, DC); end
  endtask

  task automatic test_scan();
    do_reset(2'd1);
    tick(); tick();
    pulse(3'b101);
    tick();
    checks++; if (call_leds !== 3'b101) begin errors++;
      $display("FAIL scan_leds got %b want 101", call_leds); end
    tick();
    checks++; if ({move_req, dir_up, target_floor} !== 4'b1110) begin errors++;
      $display("FAIL scan_up got %b want 1110", {move_req, dir_up, target_floor}); end
    current_floor = 2'd2;
    for (int i = 0; i < 10 && !door_open; i++) tick();
    checks++; if (door_open !== 1'b1 || call_leds !== 3'b001) begin errors++;
      $display("FAIL scan_first_stop got door=%b leds=%b want 1 001", door_open, call_leds); end
    for (int i = 0; i < 10 && door_open; i++) tick();
    for (int i = 0; i < 10 && !move_req; i++) tick();
    checks++; if ({move_req, dir_up, target_floor} !== 4'b1000) begin errors++;
      $display("FAIL scan_reverse got %b want 1000", {move_req, dir_up, target_floor}); end
    current_floor = 2'd1; tick();
    current_floor = 2'd0;
    for (int i = 0; i < 10 && !door_open; i++) tick();
    checks++; if (door_open !== 1'b1 || call_leds !== 3'b000) begin errors++;
      $display("FAIL scan_second_stop got door=%b leds=%b want 1 000", door_open, call_leds); end
  endtask

  task automatic test_emergency();
    do_reset(2'd0);
    pulse(3'b100); tick(); tick();
    current_floor = 2'd1;
    sos_pulse();
    checks++; if ({move_req, emergency_led, sos_led, call_leds} !== 6'b011100) begin errors++;
      $display("FAIL sos_enter got %b want 011100", {move_req, emergency_led, sos_led, call_leds}); end
    pulse(3'b001); tick(); tick();
    checks++; if (call_leds !== 3'b100 || emergency_led !== 1'b1) begin errors++;
      $display("FAIL sos_ignore got leds=%b em=%b want 100 1", call_leds, emergency_led); end
    sos_pulse();
    checks++; if ({move_req, emergency_led, sos_led} !== 3'b000) begin errors++;
      $display("FAIL sos_exit got %b want 000", {move_req, emergency_led, sos_led}); end
    tick();
    checks++; if ({move_req, dir_up, target_floor} !== 4'b1110) begin errors++;
      $display("FAIL sos_resume got %b want 1110", {move_req, dir_up, target_floor}); end
  endtask

  task automatic test_illegal_floor();
    do_reset(2'd0);
    tick();
    current_floor = 2'b11; tick();
    checks++; if ({move_req, door_open, emergency_led, sos_led} !== 4'b0011) begin errors++;
      $display("FAIL illegal_enter got %b want 0011", {move_req, door_open, emergency_led, sos_led}); end
    current_floor = 2'd0; tick();
    checks++; if (emergency_led !== 1'b1) begin errors++;
      $display("FAIL illegal_latched got %b want 1", emergency_led); end
    sos_pulse();
    checks++; if (emergency_led !== 1'b0) begin errors++;
      $display("FAIL illegal_exit got %b want 0", emergency_led); end
  endtask

  task automatic test_weight();
    int n;
    do_reset(2'd0);
    tick();
    pulse(3'b001); tick();
    checks++; if (door_open !== 1'b1 || call_leds !== 3'b000) begin errors++;
      $display("FAIL here_press got door=%b leds=%b want 1 000", door_open, call_leds); end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!door_open) break;
      if (i == 1) begin
        checks++; if (weight_led !== WEIGHT_EN) begin errors++;
          $display("FAIL weight_led got %b want %b", weight_led, WEIGHT_EN); end
      end
      n++;
      weight_sensor = (i < 5);
      tick();
    end
    weight_sensor = 0;
    checks++; if (n !== (WEIGHT_EN ? DC + 5 : DC)) begin errors++;
      $display("FAIL weight_door_len got %0d want %0d", n, WEIGHT_EN ? DC + 5 : DC); end
  endtask

  task automatic test_reset_mid();
    do_reset(2'd0);
    pulse(3'b100); tick(); tick();
    sos_pulse();
    reset = 1; tick();
    checks++;
    if ({move_req, dir_up, target_floor, door_open, call_leds, sos_led, emergency_led, weight_led} !== 11'b01000000000) begin
      errors++; $display("FAIL reset_mid got %b want 01000000000",
        {move_req, dir_up, target_floor, door_open, call_leds, sos_led, emergency_led, weight_led});
    end
    reset = 0;
  endtask

  task automatic test_random();
    bit [1:0] saved;
    bit [10:0] exp_v, got_v;
    int shown;
    shown = 0; saved = 0;
    do_reset(2'd0);
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      {rd_button, nd_button, st_button} = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      sos_button = ($urandom_range(0, 49) == 0);
      weight_sensor = ($urandom_range(0, 3) == 0);
      if (current_floor == 2'b11) current_floor = saved;
      else if ($urandom_range(0, 199) == 0) begin saved = current_floor; current_floor = 2'b11; end
      else if (move_req && current_floor != target_floor)
        current_floor = (current_floor < target_floor) ? current_floor + 2'd1 : current_floor - 2'd1;
      tick();
      exp_v = {m_move, m_dir, m_target, m_door, m_pend, m_alarm, m_alarm, m_wled};
      got_v = {move_req, dir_up, target_floor, door_open, call_leds, sos_led, emergency_led, weight_led};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        if (shown < 20) begin
          shown++; $display("FAIL random_cycle %0d got %b want %b", c, got_v, exp_v);
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan();
    test_emergency();
    test_illegal_floor();
    test_weight();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/call_scheduler.md
# call_scheduler

Upstream stage of the elevator's `movement` block: registers floor-call button presses, runs a directional (SCAN) scheduler and drives the move request, direction and target floor that `movement` consumes. It also owns door timing, SOS emergency latching and the overweight interlock, and reports back via the call, SOS, weight and emergency LEDs. It runs on the divided `clk` produced by `frequency_divisor`.

## Interface
- `DOOR_CYCLES`, default 3: number of `clk` cycles the door stays open per stop; legal range 1 to 15.
- `clk`  input  1  divided system clock, one floor step per cycle.
- `reset`  input  1  synchronous, active-high reset.
- `st_button`, `nd_button`, `rd_button`  input  1 each  floor call buttons, level, active-high.
- `sos_button`  input  1  emergency button, level, active-high.
- `weight_sensor`  input  1  high when the cab is overweight.
- `current_floor`  input  2  floor reported by `movement`: 00, 01 or 10; 11 is illegal.
- `move_req`  output  1  high while the cab must travel.
- `dir_up`  output  1  travel direction: 1 is up, 0 is down.
- `target_floor`  output  2  nearest pending floor in the travel direction.
- `door_open`  output  1  door open indicator.
- `call_leds`  output  3  pending calls, bit0 = 1st floor, bit2 = 3rd floor.
- `sos_led`, `emergency_led`, `weight_led`  output  1 each  status indicators.

## Operation
- **Button edges.** Each button is registered every cycle. A rising edge (previous sample 0, current sample 1) is one press.
- **Pending calls.** A press sets the `pending` bit for that floor. The exception is a press for `current_floor` while in IDLE or DOOR_OPEN, which is served at once and never shows in `call_leds`. `call_leds` equals `pending`.
- **Direction register `dir`.** Reset value is up. It keeps its value across stops and flips only when no calls remain ahead.
- **State IDLE.**
  - No pending calls: stay in IDLE.
  - Pending bit set at `current_floor`: go to DOOR_OPEN.
  - Otherwise pick the direction. Go up if a call exists above and (`dir` is up or no call exists below); else go down.
  - Load `target_floor` with the nearest pending floor in that direction, then go to MOVING.
- **State MOVING.**
  - `move_req`=1 and `dir_up`=`dir`.
  - Each cycle, if the `pending` bit at `current_floor` is set, go to DOOR_OPEN.
  - `target_floor` updates whenever a nearer call appears in the travel direction.
- **State DOOR_OPEN.**
  - On entry: clear the `pending` bit of `current_floor`, set `door_open`=1 and clear the door counter.
  - Stay for `DOOR_CYCLES` cycles, then go to IDLE.
  - A press for `current_floor` while in this state restarts the counter.
- **State EMERGENCY.**
  - Entered from any state on a `sos_button` edge, or whenever `current_floor`=11.
  - Outputs: `move_req`=0, `door_open`=0, `sos_led`=1, `emergency_led`=1.
  - `pending` is retained; new presses are ignored.
  - The next `sos_button` edge, with a legal `current_floor`, returns to IDLE.
- **Simultaneous events.** If an SOS edge and any other event occur in the same cycle, SOS wins. Several button presses in one cycle all register.

## Timing
- All outputs are registered. Reset values:
  - `move_req`, `door_open`, `sos_led`, `emergency_led`, `weight_led`: 0
  - `call_leds`: 000
  - `target_floor`: 00
  - `dir_up`: 1
  - state: IDLE
- **Press visibility.** A press sampled at edge n shows in `call_leds` after edge n+1.
- **Press to motion.** From IDLE, `move_req` rises 2 edges after the press is sampled.
- **Stop.** When `current_floor` matches a pending floor at edge k, `move_req`=0 and `door_open`=1 after edge k+1.
- **Door duration.** `door_open` stays high for exactly `DOOR_CYCLES` cycles when the weight interlock is inactive.
- **Reset mid-operation.** Reset in any state, including EMERGENCY or mid-door, returns every register to its reset value on the next edge. Pending calls are lost.

## Configuration
- `CALL_SCHEDULER_WEIGHT_INTERLOCK_EN` defined:
  - While in DOOR_OPEN with `weight_sensor`=1, the door counter freezes, the door stays open and `weight_led`=1.
  - When `weight_sensor` returns to 0, counting resumes from the held value.
  - Outside DOOR_OPEN, `weight_led` follows `weight_sensor`, registered.
- Not defined: `weight_sensor` is ignored and `weight_led` is held at 0.

## Test plan
- **Reset values.** Assert reset 2 cycles; check all outputs equal the reset values above and state is IDLE.
- **Single call.** Floor 00 in IDLE, pulse `rd_button`.
  - `call_leds`=100, then `move_req`=1, `dir_up`=1, `target_floor`=10.
  - When `current_floor`=10: `move_req`=0, `door_open`=1 for 3 cycles, `call_leds`=000.
- **SCAN order.** At floor 01 moving up with `dir` up, press `st_button` and `rd_button`.
  - Serves 10 first, then reverses: `dir_up`=0, `target_floor`=00.
- **Emergency.** Pulse `sos_button` while MOVING with `call_leds`=100.
  - Next cycle: `move_req`=0, `emergency_led`=1, `sos_led`=1.
  - Press `st_button`: `call_leds` stays 100.
  - Second SOS pulse: returns to IDLE and resumes toward 10.
- **Illegal floor.** Drive `current_floor`=11: EMERGENCY is entered next edge.
- **Weight interlock** (macro defined). Hold `weight_sensor`=1 during DOOR_OPEN for 5 cycles.
  - `door_open` stays high for 3+5 cycles and `weight_led`=1.
  - Without the macro, `door_open` lasts 3 cycles and `weight_led`=0.
